// File: rtl/scv_pkg.sv
// Shared types and defaults for the ROM-init download path.
package scv_pkg;

    // Channel assignment of the ROM-init targets.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        CHR  = 2'd1,
        APU  = 2'd2,
        CART = 2'd3
    } rominit_ch_t;

    localparam int ROMINIT_AW_DEF = 25;

    // Per-channel byte size, element [0] is BOOT; CART spans the whole address space.
    localparam logic [3:0][ROMINIT_AW_DEF-1:0] ROMINIT_LIMIT_DEF = {
        25'h1FF_FFFF,   // CART
        25'd2048,       // APU
        25'd1024,       // CHR
        25'd4096        // BOOT
    };

    // Serializer states.
    typedef enum logic {
        UNPACK_IDLE = 1'b0,
        UNPACK_EMIT = 1'b1
    } unpack_state_t;

endpackage

// File: rtl/rominit_router_if.sv
// Download-side and ROM-init-side signals of the router.
interface rominit_router_if #(
    parameter int NCH = 4,
    parameter int AW  = 25,
    parameter int DW  = 16
);
    logic           DL_ACTIVE;
    logic [7:0]     DL_INDEX;
    logic [AW-1:0]  DL_ADDR;
    logic [DW-1:0]  DL_DATA;
    logic           DL_WR;
    logic           DL_WAIT;
    logic [NCH-1:0] ROMINIT_SEL;
    logic [AW-1:0]  ROMINIT_ADDR;
    logic [7:0]     ROMINIT_DATA;
    logic           ROMINIT_VALID;
    logic [NCH-1:0] CH_DONE;
    logic [NCH-1:0] CH_OVF;
    logic           PROTO_ERR;

    // Download source side.
    modport master (
        output DL_ACTIVE, DL_INDEX, DL_ADDR, DL_DATA, DL_WR,
        input  DL_WAIT, ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID,
        input  CH_DONE, CH_OVF, PROTO_ERR
    );

    // Router side.
    modport slave (
        input  DL_ACTIVE, DL_INDEX, DL_ADDR, DL_DATA, DL_WR,
        output DL_WAIT, ROMINIT_SEL, ROMINIT_ADDR, ROMINIT_DATA, ROMINIT_VALID,
        output CH_DONE, CH_OVF, PROTO_ERR
    );
endinterface

// File: rtl/rominit_unpack.sv
// Word-to-byte serializer: latches a download word and emits it one byte per cycle.
module rominit_unpack
    import scv_pkg::*;
#(
    parameter int AW  = 25,
    parameter int BPW = 2,
    parameter int DW  = 8 * BPW
) (
    input  logic          CLK,
    input  logic          RESB,
    input  logic          wr,
    input  logic [DW-1:0] data,
    input  logic [AW-1:0] addr,
    output logic          accept,
    output logic          dl_wait,
    output logic          busy,
    output logic          busy_nxt,
    output logic [7:0]    byte_data,
    output logic [AW-1:0] byte_addr
);
    localparam int KW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(BPW - 1);

    unpack_state_t state_q, state_nxt;
    logic [KW-1:0] k_q;
    logic [DW-1:0] word_q;
    logic [AW-1:0] addr_q;
    logic          last;

    // State register.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) state_q <= UNPACK_IDLE;
        else       state_q <= state_nxt;
    end

    // Next state: a new word may be taken on the last byte, keeping BPW=1 gapless.
    always_comb begin
        state_nxt = state_q;
        case (state_q)
            UNPACK_IDLE: if (accept) state_nxt = UNPACK_EMIT;
            UNPACK_EMIT: if (last && !accept) state_nxt = UNPACK_IDLE;
            default:     state_nxt = UNPACK_IDLE;
        endcase
    end

    // Outputs: backpressure, accept strobe and the byte currently addressed by k.
    always_comb begin
        busy      = (state_q == UNPACK_EMIT);
        last      = (k_q == K_LAST);
        dl_wait   = busy && !last;
        accept    = wr && !dl_wait;
        busy_nxt  = (state_nxt == UNPACK_EMIT);
        byte_data = word_q[8*int'(k_q) +: 8];
        byte_addr = addr_q + AW'(k_q);
    end

    // Byte counter restarts on every accepted word.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB)                k_q <= '0;
        else if (accept)          k_q <= '0;
        else if (busy && !last)   k_q <= k_q + 1'b1;
    end

    // Word and base address capture; pure data, no reset needed.
    always_ff @(posedge CLK) begin
        if (accept) begin
            word_q <= data;
            addr_q <= addr;
        end
    end
endmodule

// File: rtl/rominit_router.sv
// Routes download words to one-hot ROM-init channels as a byte stream with limit and session tracking.
module rominit_router
    import scv_pkg::*;
#(
    parameter int NCH      = 4,
    parameter int AW       = 25,
    parameter int BPW      = 2,
    parameter int IDX_BASE = 0,
    parameter logic [NCH-1:0][AW-1:0] CH_LIMIT = ROMINIT_LIMIT_DEF
) (
    input logic CLK,
    input logic RESB,
    rominit_router_if.slave bus
);
    localparam int DW = 8 * BPW;
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1;

    int             idx_off;
    logic           idx_ok;
    logic [CW-1:0]  idx_ch;
    logic [NCH-1:0] idx_onehot;

    logic           accept, dl_wait, busy, busy_nxt;
    logic [7:0]     byte_data;
    logic [AW-1:0]  byte_addr;
    logic           byte_ovf, byte_vld;

    logic [CW-1:0]  wch_q;
    logic           wok_q;
    logic [NCH-1:0] sel_q;
    logic [AW-1:0]  addr_h;
    logic [7:0]     data_h;

    logic           act_q, pend_q, perr_q, sess_ok_q;
    logic [CW-1:0]  sess_ch_q;
    logic [NCH-1:0] done_q, ovf_q, done_nxt, ovf_nxt;
    logic           rise, fall, drain_req, drain_done;

    // Index decode of the current session target.
    always_comb begin
        idx_off    = int'(bus.DL_INDEX) - IDX_BASE;
        idx_ok     = (idx_off >= 0) && (idx_off < NCH);
        idx_ch     = CW'(idx_off);
        idx_onehot = idx_ok ? (NCH'(1) << idx_ch) : '0;
    end

    rominit_unpack #(.AW(AW), .BPW(BPW), .DW(DW)) u_unpack (
        .CLK       (CLK),
        .RESB      (RESB),
        .wr        (bus.DL_WR),
        .data      (bus.DL_DATA),
        .addr      (bus.DL_ADDR),
        .accept    (accept),
        .dl_wait   (dl_wait),
        .busy      (busy),
        .busy_nxt  (busy_nxt),
        .byte_data (byte_data),
        .byte_addr (byte_addr)
    );

    // Per-byte limit check against the channel captured with the word.
    always_comb begin
        byte_ovf = busy && wok_q && (byte_addr >= CH_LIMIT[wch_q]);
        byte_vld = busy && wok_q && !byte_ovf;
    end

    // Channel of the word in flight, captured together with the word.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            wch_q <= '0;
            wok_q <= 1'b0;
        end else if (accept) begin
            wch_q <= idx_ch;
            wok_q <= idx_ok;
        end
    end

    // Select follows the active session and stays put while a word drains.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB)                         sel_q <= '0;
        else if (bus.DL_ACTIVE && idx_ok)  sel_q <= idx_onehot;
        else if (!busy_nxt)                sel_q <= '0;
    end

    // Last emitted byte, shown on ADDR/DATA while VALID is low.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            addr_h <= '0;
            data_h <= '0;
        end else if (byte_vld) begin
            addr_h <= byte_addr;
            data_h <= byte_data;
        end
    end

    // Sticky flag updates: rise clears the addressed channel, drain after fall sets done.
    always_comb begin
        rise       = bus.DL_ACTIVE && !act_q;
        fall       = !bus.DL_ACTIVE && act_q;
        drain_req  = fall || pend_q;
        drain_done = drain_req && !busy;
        done_nxt   = done_q;
        ovf_nxt    = ovf_q;
        if (rise && idx_ok) begin
            done_nxt[idx_ch] = 1'b0;
            ovf_nxt[idx_ch]  = 1'b0;
        end
        if (byte_ovf)
            ovf_nxt[wch_q] = 1'b1;
        if (drain_done && sess_ok_q)
            done_nxt[sess_ch_q] = 1'b1;
    end

    // Session tracking and sticky flag registers.
    always_ff @(posedge CLK or negedge RESB) begin
        if (!RESB) begin
            act_q     <= 1'b0;
            pend_q    <= 1'b0;
            sess_ch_q <= '0;
            sess_ok_q <= 1'b0;
            done_q    <= '0;
            ovf_q     <= '0;
            perr_q    <= 1'b0;
        end else begin
            act_q <= bus.DL_ACTIVE;
            if (bus.DL_ACTIVE) begin
                sess_ch_q <= idx_ch;
                sess_ok_q <= idx_ok;
            end
            pend_q <= drain_req && busy && !rise;
            done_q <= done_nxt;
            ovf_q  <= ovf_nxt;
            perr_q <= perr_q | (bus.DL_WR & dl_wait);
        end
    end

    assign bus.DL_WAIT       = dl_wait;
    assign bus.ROMINIT_SEL   = sel_q;
    assign bus.ROMINIT_VALID = byte_vld;
    assign bus.ROMINIT_ADDR  = byte_vld ? byte_addr : addr_h;
    assign bus.ROMINIT_DATA  = byte_vld ? byte_data : data_h;
    assign bus.CH_DONE       = done_q;
    assign bus.CH_OVF        = ovf_q;
    assign bus.PROTO_ERR     = perr_q;
endmodule

// File: tb/tb_rominit_router.sv
// Scoreboard bench for rominit_router with a BPW=2 and a BPW=1 instance.
module tb_rominit_router;
    import scv_pkg::*;

    typedef struct packed {
        logic [3:0]  sel;
        logic [24:0] addr;
        logic [7:0]  data;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t q2[$];
    exp_t q1[$];
    int   cyc = 0;
    int   n1 = 0, first1 = 0, last1 = 0, wait1 = 0;

    rominit_router_if #(.NCH(4), .AW(25), .DW(16)) if2 ();
    rominit_router_if #(.NCH(4), .AW(25), .DW(8))  if1 ();

    rominit_router #(.NCH(4), .AW(25), .BPW(2), .IDX_BASE(0)) u2 (
        .CLK(clk), .RESB(rst_n), .bus(if2)
    );
    rominit_router #(.NCH(4), .AW(25), .BPW(1), .IDX_BASE(0)) u1 (
        .CLK(clk), .RESB(rst_n), .bus(if1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor for the BPW=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (if2.ROMINIT_VALID === 1'b1) begin
            checks++;
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL u2_unexpected_byte actual sel=%0h addr=%0h data=%0h required no byte",
                         if2.ROMINIT_SEL, if2.ROMINIT_ADDR, if2.ROMINIT_DATA);
            end else begin
                e = q2.pop_front();
                if (if2.ROMINIT_SEL !== e.sel || if2.ROMINIT_ADDR !== e.addr || if2.ROMINIT_DATA !== e.data) begin
                    errors++;
                    $display("FAIL u2_byte actual sel=%0h addr=%0h data=%0h required sel=%0h addr=%0h data=%0h",
                             if2.ROMINIT_SEL, if2.ROMINIT_ADDR, if2.ROMINIT_DATA, e.sel, e.addr, e.data);
                end
            end
        end
    end

    // Scoreboard monitor for the BPW=1 instance, also tracking pulse span and backpressure.
    always @(negedge clk) begin
        exp_t e;
        if (if1.DL_WAIT === 1'b1) wait1++;
        if (if1.ROMINIT_VALID === 1'b1) begin
            if (n1 == 0) first1 = cyc;
            last1 = cyc;
            n1++;
            checks++;
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL u1_unexpected_byte actual addr=%0h data=%0h required no byte",
                         if1.ROMINIT_ADDR, if1.ROMINIT_DATA);
            end else begin
                e = q1.pop_front();
                if (if1.ROMINIT_SEL !== e.sel || if1.ROMINIT_ADDR !== e.addr || if1.ROMINIT_DATA !== e.data) begin
                    errors++;
                    $display("FAIL u1_byte actual sel=%0h addr=%0h data=%0h required sel=%0h addr=%0h data=%0h",
                             if1.ROMINIT_SEL, if1.ROMINIT_ADDR, if1.ROMINIT_DATA, e.sel, e.addr, e.data);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        if2.DL_ACTIVE = 1'b0; if2.DL_INDEX = 8'd0; if2.DL_ADDR = '0; if2.DL_DATA = '0; if2.DL_WR = 1'b0;
        if1.DL_ACTIVE = 1'b0; if1.DL_INDEX = 8'd0; if1.DL_ADDR = '0; if1.DL_DATA = '0; if1.DL_WR = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", 32'(if2.ROMINIT_VALID), 32'd0);
        chk("rst_sel", 32'(if2.ROMINIT_SEL), 32'd0);
        chk("rst_wait", 32'(if2.DL_WAIT), 32'd0);
        chk("rst_done", 32'(if2.CH_DONE), 32'd0);
        chk("rst_ovf", 32'(if2.CH_OVF), 32'd0);
        chk("rst_perr", 32'(if2.PROTO_ERR), 32'd0);
        chk("rst_u1_valid", 32'(if1.ROMINIT_VALID), 32'd0);
        rst_n = 1'b1;
        tick(1);

        // 0xBEEF at 0x10 on BOOT splits into EF then BE
        if2.DL_ACTIVE = 1'b1; if2.DL_INDEX = 8'(BOOT);
        tick(2);
        q2.push_back('{4'b0001, 25'h10, 8'hEF});
        q2.push_back('{4'b0001, 25'h11, 8'hBE});
        if2.DL_ADDR = 25'h10; if2.DL_DATA = 16'hBEEF; if2.DL_WR = 1'b1;
        tick(1);
        if2.DL_WR = 1'b0;
        @(negedge clk); chk("wait_t1", 32'(if2.DL_WAIT), 32'd1);
        tick(1);
        @(negedge clk); chk("wait_t2", 32'(if2.DL_WAIT), 32'd0);
        chk("hold_addr", 32'(if2.ROMINIT_ADDR), 32'h11);
        chk("hold_data", 32'(if2.ROMINIT_DATA), 32'hBE);
        tick(1);
        if2.DL_ACTIVE = 1'b0;
        tick(4);
        @(negedge clk); chk("done_boot", 32'(if2.CH_DONE), 32'b0001);
        tick(1);

        // CHR limit 1024: byte at 1023 kept, byte at 1024 suppressed
        if2.DL_INDEX = 8'(CHR); if2.DL_ACTIVE = 1'b1;
        tick(2);
        q2.push_back('{4'b0010, 25'd1023, 8'h3C});
        if2.DL_ADDR = 25'd1023; if2.DL_DATA = 16'h5A3C; if2.DL_WR = 1'b1;
        tick(1);
        if2.DL_WR = 1'b0;
        @(negedge clk); chk("wait_chr", 32'(if2.DL_WAIT), 32'd1);
        tick(4);
        @(negedge clk);
        chk("ovf_chr", 32'(if2.CH_OVF), 32'b0010);
        chk("done_keep_boot", 32'(if2.CH_DONE), 32'b0001);
        chk("sel_chr", 32'(if2.ROMINIT_SEL), 32'b0010);
        tick(1);
        if2.DL_ACTIVE = 1'b0;
        tick(4);
        @(negedge clk); chk("done_chr", 32'(if2.CH_DONE), 32'b0011);
        tick(1);

        // Out-of-range index: consumed with normal timing, nothing emitted
        if2.DL_INDEX = 8'd7; if2.DL_ACTIVE = 1'b1;
        tick(2);
        @(negedge clk); chk("sel_oor", 32'(if2.ROMINIT_SEL), 32'd0);
        tick(1);
        if2.DL_ADDR = 25'h0; if2.DL_DATA = 16'h1111; if2.DL_WR = 1'b1;
        tick(1);
        if2.DL_WR = 1'b0;
        @(negedge clk);
        chk("wait_oor", 32'(if2.DL_WAIT), 32'd1);
        chk("valid_oor", 32'(if2.ROMINIT_VALID), 32'd0);
        tick(3);
        if2.DL_ACTIVE = 1'b0;
        tick(2);

        // Write during DL_WAIT is dropped and flagged
        if2.DL_INDEX = 8'(APU); if2.DL_ACTIVE = 1'b1;
        tick(2);
        @(negedge clk); chk("perr_before", 32'(if2.PROTO_ERR), 32'd0);
        tick(1);
        q2.push_back('{4'b0100, 25'h20, 8'h34});
        q2.push_back('{4'b0100, 25'h21, 8'h12});
        if2.DL_ADDR = 25'h20; if2.DL_DATA = 16'h1234; if2.DL_WR = 1'b1;
        tick(1);
        if2.DL_ADDR = 25'h30; if2.DL_DATA = 16'hFFFF;
        tick(1);
        if2.DL_WR = 1'b0;
        @(negedge clk); chk("perr_set", 32'(if2.PROTO_ERR), 32'd1);
        tick(4);

        // Reset during the first byte: everything clears at once, second byte never appears
        if2.DL_ADDR = 25'h40; if2.DL_DATA = 16'hCAFE; if2.DL_WR = 1'b1;
        tick(1);
        if2.DL_WR = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(if2.ROMINIT_VALID), 32'd0);
        chk("arst_sel", 32'(if2.ROMINIT_SEL), 32'd0);
        chk("arst_wait", 32'(if2.DL_WAIT), 32'd0);
        chk("arst_perr", 32'(if2.PROTO_ERR), 32'd0);
        chk("arst_ovf", 32'(if2.CH_OVF), 32'd0);
        chk("arst_done", 32'(if2.CH_DONE), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        // Accepted on the very first edge after release
        q2.push_back('{4'b0100, 25'h50, 8'h02});
        q2.push_back('{4'b0100, 25'h51, 8'h01});
        if2.DL_ADDR = 25'h50; if2.DL_DATA = 16'h0102; if2.DL_WR = 1'b1;
        tick(1);
        if2.DL_WR = 1'b0;
        tick(3);

        // DL_ACTIVE falls mid-word: second byte still emitted under the same select
        q2.push_back('{4'b0100, 25'h60, 8'h5A});
        q2.push_back('{4'b0100, 25'h61, 8'hA5});
        if2.DL_ADDR = 25'h60; if2.DL_DATA = 16'hA55A; if2.DL_WR = 1'b1;
        tick(1);
        if2.DL_WR = 1'b0; if2.DL_ACTIVE = 1'b0;
        tick(1);
        @(negedge clk); chk("done_not_early", 32'(if2.CH_DONE), 32'd0);
        tick(2);
        @(negedge clk); chk("done_apu", 32'(if2.CH_DONE), 32'b0100);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        tick(1);

        // BPW=1: 4096 back-to-back bytes into BOOT
        if1.DL_INDEX = 8'(BOOT); if1.DL_ACTIVE = 1'b1;
        tick(2);
        for (int i = 0; i < 4096; i++) begin
            q1.push_back('{4'b0001, 25'(i), 8'(i)});
            if1.DL_ADDR = 25'(i); if1.DL_DATA = 8'(i); if1.DL_WR = 1'b1;
            tick(1);
        end
        if1.DL_WR = 1'b0;
        tick(3);
        if1.DL_ACTIVE = 1'b0;
        tick(4);
        @(negedge clk);
        chk("u1_done", 32'(if1.CH_DONE), 32'b0001);
        chk("u1_ovf", 32'(if1.CH_OVF), 32'd0);
        chk("u1_count", 32'(n1), 32'd4096);
        chk("u1_span", 32'(last1 - first1), 32'd4095);
        chk("u1_wait", 32'(wait1), 32'd0);
        chk("q1_drained", 32'(q1.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
